// File: rtl/psg_pkg.sv
// psg_pkg: shared constants and types for the programmable sound generator.
//   ATTN_TABLE      - 8-bit attenuation-to-volume table (index 0 = loudest)
//   ADDR_FREQ/ATTN  - register-type values carried in wr_addr[0]
//   noise_rate_e    - encodings of noise control [1:0] (shift source select)
//   RST_*           - reset values of the programmable registers
//   scale_vol       - rescales a table entry to an arbitrary channel width
package psg_pkg;

    localparam logic [7:0] ATTN_TABLE [16] = '{
        8'd255, 8'd203, 8'd161, 8'd128, 8'd102, 8'd81, 8'd64, 8'd51,
        8'd40,  8'd32,  8'd26,  8'd20,  8'd16,  8'd13, 8'd10, 8'd0
    };

    localparam logic ADDR_FREQ = 1'b0;
    localparam logic ADDR_ATTN = 1'b1;

    typedef enum logic [1:0] {
        NOISE_DIV16 = 2'b00,
        NOISE_DIV32 = 2'b01,
        NOISE_DIV64 = 2'b10,
        NOISE_TONE  = 2'b11
    } noise_rate_e;

    localparam int         RST_FREQ      = 0;
    localparam logic [3:0] RST_ATTN      = 4'hF;
    localparam logic [2:0] RST_NOISE_CTL = 3'b100;

    // Full scale of the 8-bit table (255) maps to all-ones at the target width.
    function automatic logic [31:0] scale_vol(input int width, input logic [3:0] idx);
        longint full;
        full = (longint'(1) << width) - 1;
        return 32'((longint'(ATTN_TABLE[idx]) * full) / 255);
    endfunction

endpackage

// File: rtl/psg_if.sv
// psg_if: register write bus of the sound generator.
//   wr_en   - write strobe, one register write per asserted cycle
//   wr_addr - {channel, type}; type bit0: 0 = frequency/noise control, 1 = attenuation
//   wr_data - write value, LSB aligned
// Modports: master drives the bus, slave (psg_core) receives it.
interface psg_if #(
    parameter int ADDR_BITS = 3,
    parameter int FREQ_BITS = 10
);
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [FREQ_BITS-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/psg_tone_channel.sv
// psg_tone_channel: one square-wave tone generator advanced by the shared tick.
//   clk, reset - system clock, asynchronous active-high reset
//   tick       - prescaler tick, one clk wide
//   freq       - half-period in ticks (0 and 1 hold the output high)
//   tone       - registered square-wave output, period 2*freq ticks
module psg_tone_channel
    import psg_pkg::*;
#(
    parameter int FREQ_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [FREQ_BITS-1:0] freq,
    output logic                 tone
);

    logic [FREQ_BITS-1:0] count;

    // The counter is not touched by frequency writes; a new value is picked
    // up at the next reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            tone  <= 1'b0;
        end else if (tick) begin
            if (freq <= FREQ_BITS'(1)) begin
                count <= '0;
                tone  <= 1'b1;
            end else if (count == '0) begin
                count <= freq - FREQ_BITS'(1);
                tone  <= ~tone;
            end else begin
                count <= count - FREQ_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/psg_core.sv
// psg_core: NUM_TONES square-wave channels plus one LFSR noise channel,
// per-channel attenuation and a saturating mixer.
//   clk, reset  - system clock, asynchronous active-high reset
//   bus         - psg_if.slave register write bus
//   channel_out - raw 1-bit waveforms, noise at index NUM_TONES
//   audio_out   - registered mixed sample
module psg_core
    import psg_pkg::*;
#(
    parameter int NUM_TONES           = 3,
    parameter int FREQ_BITS           = 10,
    parameter int CHANNEL_OUTPUT_BITS = 8,
    parameter int MASTER_OUTPUT_BITS  = 8,
    parameter int PRESCALE            = 16,
    parameter int LFSR_BITS           = 16,
    parameter int WHITE_TAP           = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    psg_if.slave                          bus,
    output logic [NUM_TONES:0]            channel_out,
    output logic [MASTER_OUTPUT_BITS-1:0] audio_out
);

    localparam int ADDR_BITS = $clog2(NUM_TONES + 1) + 1;
    localparam int CH_BITS   = ADDR_BITS - 1;
    localparam int CW        = CHANNEL_OUTPUT_BITS;
    localparam int MW        = MASTER_OUTPUT_BITS;
    localparam int SUM_BITS  = CW + $clog2(NUM_TONES + 1);
    localparam int PS_BITS   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [LFSR_BITS-1:0] LFSR_SEED = LFSR_BITS'(1) << (LFSR_BITS - 1);

    // ---------------- prescaler ----------------
    logic [PS_BITS-1:0] ps_count;
    logic               tick;

    assign tick = (ps_count == PS_BITS'(PRESCALE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_count <= '0;
        end else if (tick) begin
            ps_count <= '0;
        end else begin
            ps_count <= ps_count + PS_BITS'(1);
        end
    end

    // ---------------- register file ----------------
    logic [CH_BITS-1:0]   wr_ch;
    logic                 wr_attn;
    logic [NUM_TONES:0]   hit;
    logic                 noise_wr;
    logic [FREQ_BITS-1:0] freq [NUM_TONES];
    logic [3:0]           attn [NUM_TONES+1];
    logic [2:0]           noise_ctl;

    assign wr_ch   = bus.wr_addr[ADDR_BITS-1:1];
    assign wr_attn = (bus.wr_addr[0] == ADDR_ATTN);

    // Channel indices above NUM_TONES match no hit bit and are dropped.
    always_comb begin
        hit = '0;
        for (int i = 0; i <= NUM_TONES; i++) begin
            hit[i] = bus.wr_en && (wr_ch == CH_BITS'(i));
        end
    end

    assign noise_wr = hit[NUM_TONES] && !wr_attn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TONES; i++) freq[i] <= FREQ_BITS'(RST_FREQ);
            for (int i = 0; i <= NUM_TONES; i++) attn[i] <= RST_ATTN;
            noise_ctl <= RST_NOISE_CTL;
        end else begin
            for (int i = 0; i < NUM_TONES; i++) begin
                if (hit[i] && !wr_attn) freq[i] <= bus.wr_data;
            end
            for (int i = 0; i <= NUM_TONES; i++) begin
                if (hit[i] && wr_attn) attn[i] <= bus.wr_data[3:0];
            end
            if (noise_wr) noise_ctl <= bus.wr_data[2:0];
        end
    end

    // ---------------- tone channels ----------------
    logic [NUM_TONES-1:0] tone_bits;

    for (genvar g = 0; g < NUM_TONES; g++) begin : g_tone
        psg_tone_channel #(
            .FREQ_BITS (FREQ_BITS)
        ) u_tone (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .freq  (freq[g]),
            .tone  (tone_bits[g])
        );
    end

    // ---------------- noise channel ----------------
    // ndiv bit k toggles every 2^k ticks, so bits 4/5/6 give 16/32/64.
    logic [6:0]           ndiv;
    logic                 src;
    logic                 src_d;
    logic                 shift_ev;
    logic                 feedback;
    logic [LFSR_BITS-1:0] lfsr;

    always_comb begin
        src = 1'b0;
        case (noise_rate_e'(noise_ctl[1:0]))
            NOISE_DIV16: src = ndiv[4];
            NOISE_DIV32: src = ndiv[5];
            NOISE_DIV64: src = ndiv[6];
            NOISE_TONE:  src = tone_bits[NUM_TONES-1];
            default:     src = 1'b0;
        endcase
    end

    // Rising edge of the registered source; the shift lands one clk later.
    assign shift_ev = src && !src_d;
    assign feedback = noise_ctl[2] ? (lfsr[0] ^ lfsr[WHITE_TAP]) : lfsr[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ndiv  <= '0;
            src_d <= 1'b0;
            lfsr  <= LFSR_SEED;
        end else begin
            src_d <= src;
            if (noise_wr) begin
                ndiv <= '0;
                lfsr <= LFSR_SEED;
            end else begin
                if (tick) ndiv <= ndiv + 7'd1;
                if (shift_ev) lfsr <= {feedback, lfsr[LFSR_BITS-1:1]};
            end
        end
    end

    assign channel_out = {lfsr[0], tone_bits};

    // ---------------- attenuation and mixer ----------------
    logic [CW-1:0]       vol_tbl [16];
    logic [SUM_BITS-1:0] sum;

    for (genvar g = 0; g < 16; g++) begin : g_vol
        assign vol_tbl[g] = CW'(scale_vol(CW, 4'(g)));
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i <= NUM_TONES; i++) begin
            if (channel_out[i]) sum = sum + SUM_BITS'(vol_tbl[attn[i]]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            audio_out <= '0;
        end else if (|sum[SUM_BITS-1:CW]) begin
            audio_out <= '1;
        end else begin
            audio_out <= sum[CW-1 -: MW];
        end
    end

endmodule

// File: tb/tb_psg_core.sv
module tb_psg_core;

    localparam int AB = 3;
    localparam int FB = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] channel_out;
    logic [7:0] audio_out;

    psg_if #(.ADDR_BITS(AB), .FREQ_BITS(FB)) bus ();

    psg_core dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .channel_out (channel_out),
        .audio_out   (audio_out)
    );

    always #5 clk = ~clk;

    // Edges since reset release; a negedge sample at cyc = n follows edge n.
    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int         cyc;
        logic [3:0] ch_mask;
        logic [3:0] ch_exp;
        bit         chk_audio;
        logic [7:0] audio_exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int tbl [16] = '{255, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 16, 13, 10, 0};

    function automatic void push(input int c, input logic [3:0] m, input logic [3:0] e,
                                 input bit ca, input logic [7:0] ae);
        exp_t x;
        int   i;
        x.cyc = c; x.ch_mask = m; x.ch_exp = e; x.chk_audio = ca; x.audio_exp = ae;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, x);
    endfunction

    // Tone output after n edges: ticks land on edges 16, 32, ...; toggles
    // happen at ticks 1, f+1, 2f+1, ...
    function automatic bit tone_model(input int n, input int f);
        int k;
        k = n / 16;
        if (k == 0) return 1'b0;
        if (f <= 1) return 1'b1;
        return 1'(((k - 1) / f + 1) % 2);
    endfunction

    // Number of noise shifts by edge n when the divider restarted at edge w
    // (source 16 ticks: first rise 16 ticks after w, then every 32 ticks).
    function automatic int shifts(input int w, input int n);
        int r1;
        r1 = 16 * (w / 16 + 16);
        if (n < r1) return 0;
        return (n - r1) / 512 + 1;
    endfunction

    function automatic bit lfsr_bit0(input bit white, input int s);
        int st;
        int fbk;
        st = 32'h8000;
        for (int i = 0; i < s; i++) begin
            fbk = white ? ((st & 1) ^ ((st >> 3) & 1)) : (st & 1);
            st  = (st >> 1) | (fbk << 15);
        end
        return st[0];
    endfunction

    function automatic logic [7:0] sat(input int s);
        return (s > 255) ? 8'd255 : 8'(s);
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_tests++; n_fail++;
            $display("FAIL missed_check expected at cyc %0d, now cyc %0d", e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            if (e.ch_mask != 4'b0) begin
                n_tests++;
                if ((channel_out & e.ch_mask) !== (e.ch_exp & e.ch_mask)) begin
                    n_fail++;
                    $display("FAIL channel_out cyc %0d got %b want %b (mask %b)",
                             cyc, channel_out, e.ch_exp, e.ch_mask);
                end
            end
            if (e.chk_audio) begin
                n_tests++;
                if (audio_out !== e.audio_exp) begin
                    n_fail++;
                    $display("FAIL audio_out cyc %0d got %0d want %0d", cyc, audio_out, e.audio_exp);
                end
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [9:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int k;
        k = 0;
        while (sb.size() > 0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout %0d checks pending", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int f, a, n, w, r, s;
        int av [3];
        int pts [$];
        bit b;

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

        // Reset state, then idle: silence and noise bit low for 2000 clk.
        push(0, 4'b1111, 4'b0000, 1'b1, 8'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (n = 50; n <= 2000; n += 50) push(n, 4'b1000, 4'b0000, 1'b1, 8'd0);
        drain(2100);

        // Tone 0 with random frequency / attenuation (first pass f=4, attn 0).
        for (int it = 0; it < 4; it++) begin
            f = (it == 0) ? 4 : $urandom_range(2, 12);
            a = (it == 0) ? 0 : $urandom_range(0, 14);
            do_reset();
            wr(3'd0, 10'(f));
            wr(3'd1, 10'(a));
            for (n = 8; n <= 640; n += 8) begin
                push(n, 4'b1111,
                     {lfsr_bit0(1'b1, shifts(0, n)), tone_model(n, 0), tone_model(n, 0), tone_model(n, f)},
                     1'b1, tone_model(n - 1, f) ? 8'(tbl[a]) : 8'd0);
            end
            drain(800);
        end

        // Three constant-high tones through the saturating mixer.
        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < 3; c++) av[c] = (it == 0) ? 0 : (it == 1) ? 6 : $urandom_range(0, 15);
            do_reset();
            wr(3'd0, 10'd1); wr(3'd2, 10'd1); wr(3'd4, 10'd1);
            wr(3'd1, 10'(av[0])); wr(3'd3, 10'(av[1])); wr(3'd5, 10'(av[2]));
            foreach (pts[i]) pts.delete();
            pts = '{24, 40, 100};
            foreach (pts[i]) push(pts[i], 4'b0111, 4'b0111, 1'b1, sat(tbl[av[0]] + tbl[av[1]] + tbl[av[2]]));
            drain(150);
        end

        // Periodic noise, divider 16: one high pulse of 32 ticks every 16 shifts.
        do_reset();
        wr(3'd6, 10'd0);
        wr(3'd7, 10'd0);
        r = 256;
        pts = '{r + 512*13 + 256, r + 512*14 - 8, r + 512*14 + 8, r + 512*14 + 256,
                r + 512*15 - 8, r + 512*15 + 8, r + 512*15 + 256, r + 512*14 + 4096,
                r + 512*14 + 8192 - 8, r + 512*14 + 8192 + 8};
        foreach (pts[i]) begin
            b = lfsr_bit0(1'b0, shifts(1, pts[i]));
            push(pts[i], 4'b1000, {b, 3'b000}, 1'b1, b ? 8'd255 : 8'd0);
        end
        drain(16000);

        // White noise: low for 14 shifts, high after the 15th; rewrite restarts.
        do_reset();
        wr(3'd6, 10'd4);
        wr(3'd7, 10'd0);
        push(200, 4'b1000, 4'b0000, 1'b1, 8'd0);
        for (s = 1; s <= 15; s++) begin
            n = 256 + 512 * (s - 1) + 256;
            b = lfsr_bit0(1'b1, s);
            push(n, 4'b1000, {b, 3'b000}, 1'b1, b ? 8'd255 : 8'd0);
        end
        drain(8000);
        while (cyc < 7700) @(negedge clk);
        w = cyc + 1;
        wr(3'd6, 10'd4);
        r = 16 * (w / 16 + 16);
        push(w + 8, 4'b1000, 4'b0000, 1'b1, 8'd0);
        b = lfsr_bit0(1'b1, 14);
        push(r + 512*13 + 256, 4'b1000, {b, 3'b000}, 1'b1, b ? 8'd255 : 8'd0);
        b = lfsr_bit0(1'b1, 15);
        push(r + 512*14 + 256, 4'b1000, {b, 3'b000}, 1'b1, b ? 8'd255 : 8'd0);
        drain(8500);

        // Reset mid-waveform clears outputs before the next clock edge.
        do_reset();
        wr(3'd0, 10'd4);
        wr(3'd1, 10'd0);
        push(40, 4'b0001, 4'b0001, 1'b1, 8'd255);
        drain(100);
        @(posedge clk);
        #1 reset = 1'b1;
        push(0, 4'b1111, 4'b0000, 1'b1, 8'd0);
        drain(10);
        @(negedge clk);
        reset = 1'b0;
        push(20, 4'b1111, 4'b0111, 1'b1, 8'd0);
        push(100, 4'b1111, 4'b0111, 1'b1, 8'd0);
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
